// File: rtl/id_ex_pkg.sv
// Control-bundle layout and constants shared by the ID/EX pipeline register.
package id_ex_pkg;

   localparam int CTRL_WIDTH = 16;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Bit positions inside in_Ctrl / out_Ctrl
   localparam int CTRL_REGDST        = 0;
   localparam int CTRL_BRANCHEQ      = 1;
   localparam int CTRL_BRANCHNE      = 2;
   localparam int CTRL_ALUOP_LO      = 3;
   localparam int CTRL_ALUOP_HI      = 5;
   localparam int CTRL_ALUSRC        = 6;
   localparam int CTRL_REGWRITE      = 7;
   localparam int CTRL_MEMWRITE      = 8;
   localparam int CTRL_MEMREAD       = 9;
   localparam int CTRL_MEMTOREG      = 10;
   localparam int CTRL_SHAMTSELECTOR = 11;
   localparam int CTRL_REGISTERORPC  = 12;
   localparam int CTRL_ALUMEMORPC    = 13;
   localparam int CTRL_JUMP          = 14;
   localparam int CTRL_RESERVED      = 15;

   typedef logic [CTRL_WIDTH-1:0] ctrl_t;

   // Destination register select: rd for R-type, rt otherwise.
   function automatic logic [4:0] dest_reg(input logic reg_dst, input logic [4:0] rd,
                                           input logic [4:0] rt);
      return reg_dst ? rd : rt;
   endfunction

endpackage

// File: rtl/id_ex_pipeline_register_hazard_detection_unit.sv
// Load-use hazard detector: the instruction in EX is a load whose rt is read
// by the instruction currently in ID. A load to $0 never creates a hazard.
module hazard_detection_unit (
   input  logic       i_ex_mem_read,
   input  logic [4:0] i_ex_rt,
   input  logic [4:0] i_id_rs,
   input  logic [4:0] i_id_rt,
   output logic       o_hazard
);

   logic w_rs_match;
   logic w_rt_match;

   // Compare the EX load destination against both ID source fields.
   always_comb begin
      w_rs_match = (i_ex_rt == i_id_rs);
      w_rt_match = (i_ex_rt == i_id_rt);
      o_hazard   = i_ex_mem_read && (i_ex_rt != 5'd0) && (w_rs_match || w_rt_match);
   end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with load-use stall/bubble insertion, branch
// squash, and saturating stall/flush event counters for debug.
module id_ex_pipeline_register
   import id_ex_pkg::*;
#(
   parameter int NBits     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_Flush,
   input  logic [NBits-1:0]      in_Instruction,
   input  logic [NBits-1:0]      in_PC_4,
   input  logic [NBits-1:0]      in_ReadData1,
   input  logic [NBits-1:0]      in_ReadData2,
   input  logic [NBits-1:0]      in_InmmediateExtend,
   input  logic [NBits-1:0]      in_ShamtExtend,
   input  logic [CTRL_WIDTH-1:0] in_Ctrl,
   output logic [NBits-1:0]      out_Instruction,
   output logic [NBits-1:0]      out_PC_4,
   output logic [NBits-1:0]      out_ReadData1,
   output logic [NBits-1:0]      out_ReadData2,
   output logic [NBits-1:0]      out_InmmediateExtend,
   output logic [NBits-1:0]      out_ShamtExtend,
   output logic [CTRL_WIDTH-1:0] out_Ctrl,
   output logic [4:0]            out_WriteRegister,
   output logic                  out_Stall,
   output logic [CNT_WIDTH-1:0]  out_StallCount,
   output logic [CNT_WIDTH-1:0]  out_FlushCount
);

   logic [NBits-1:0]     r_instr;
   logic [NBits-1:0]     r_pc_4;
   logic [NBits-1:0]     r_rd1;
   logic [NBits-1:0]     r_rd2;
   logic [NBits-1:0]     r_imm;
   logic [NBits-1:0]     r_shamt;
   ctrl_t                r_ctrl;
   logic [4:0]           r_wr_reg;
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;

   logic                 w_hazard;
   logic                 w_bubble;

   hazard_detection_unit u_hazard (
      .i_ex_mem_read (r_ctrl[CTRL_MEMREAD]),
      .i_ex_rt       (r_instr[20:16]),
      .i_id_rs       (in_Instruction[25:21]),
      .i_id_rt       (in_Instruction[20:16]),
      .o_hazard      (w_hazard)
   );

   // A flush overrides the stall request: the ID instruction is discarded
   // anyway, so PC/IF-ID must be allowed to move to the branch target.
   assign out_Stall = w_hazard && !in_Flush;
   assign w_bubble  = in_Flush || w_hazard;

   // Pipeline payload: load a bubble (NOP, zero control) or the ID values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instr  <= NBits'(NOP_INSTR);
         r_pc_4   <= '0;
         r_rd1    <= '0;
         r_rd2    <= '0;
         r_imm    <= '0;
         r_shamt  <= '0;
         r_ctrl   <= '0;
         r_wr_reg <= '0;
      end else if (w_bubble) begin
         r_instr  <= NBits'(NOP_INSTR);
         r_pc_4   <= '0;
         r_rd1    <= '0;
         r_rd2    <= '0;
         r_imm    <= '0;
         r_shamt  <= '0;
         r_ctrl   <= '0;
         r_wr_reg <= '0;
      end else begin
         r_instr  <= in_Instruction;
         r_pc_4   <= in_PC_4;
         r_rd1    <= in_ReadData1;
         r_rd2    <= in_ReadData2;
         r_imm    <= in_InmmediateExtend;
         r_shamt  <= in_ShamtExtend;
         r_ctrl   <= in_Ctrl;
         r_wr_reg <= dest_reg(in_Ctrl[CTRL_REGDST], in_Instruction[15:11],
                              in_Instruction[20:16]);
      end
   end

   // Flush counter, saturating at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flush_cnt <= '0;
      end else if (in_Flush && (r_flush_cnt != '1)) begin
         r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   // Stall counter, saturating; a flush in the same cycle masks the stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (out_Stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign out_Instruction      = r_instr;
   assign out_PC_4             = r_pc_4;
   assign out_ReadData1        = r_rd1;
   assign out_ReadData2        = r_rd2;
   assign out_InmmediateExtend = r_imm;
   assign out_ShamtExtend      = r_shamt;
   assign out_Ctrl             = r_ctrl;
   assign out_WriteRegister    = r_wr_reg;
   assign out_StallCount       = r_stall_cnt;
   assign out_FlushCount       = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for the ID/EX pipeline register.
module tb_id_ex_pipeline_register;

   localparam logic [15:0] C_RTYPE = 16'h0081;   // RegDst | RegWrite
   localparam logic [15:0] C_LW    = 16'h06C0;   // ALUSrc | RegWrite | MemRead | MemtoReg

   localparam logic [31:0] I_ADD3    = 32'h0022_1820; // add $3,$1,$2
   localparam logic [31:0] I_LW8     = 32'h8D28_0000; // lw  $8,0($9)
   localparam logic [31:0] I_ADD_RS8 = 32'h010B_5020; // add $10,$8,$11
   localparam logic [31:0] I_LW0     = 32'h8D20_0000; // lw  $0,0($9)
   localparam logic [31:0] I_ADD_RS0 = 32'h000B_5020; // add $10,$0,$11
   localparam logic [31:0] I_ADD_IND = 32'h018D_7020; // add $14,$12,$13
   localparam logic [31:0] I_ADD_RT8 = 32'h0168_5020; // add $10,$11,$8

   logic        clk;
   logic        reset;
   logic        in_Flush;
   logic [31:0] in_Instruction, in_PC_4, in_ReadData1, in_ReadData2;
   logic [31:0] in_InmmediateExtend, in_ShamtExtend;
   logic [15:0] in_Ctrl;
   logic [31:0] out_Instruction, out_PC_4, out_ReadData1, out_ReadData2;
   logic [31:0] out_InmmediateExtend, out_ShamtExtend;
   logic [15:0] out_Ctrl;
   logic [4:0]  out_WriteRegister;
   logic        out_Stall;
   logic [15:0] out_StallCount, out_FlushCount;

   int n_cmp = 0;
   int n_err = 0;

   id_ex_pipeline_register #(.NBits(32), .CNT_WIDTH(16)) dut (
      .clk                  (clk),
      .reset                (reset),
      .in_Flush             (in_Flush),
      .in_Instruction       (in_Instruction),
      .in_PC_4              (in_PC_4),
      .in_ReadData1         (in_ReadData1),
      .in_ReadData2         (in_ReadData2),
      .in_InmmediateExtend  (in_InmmediateExtend),
      .in_ShamtExtend       (in_ShamtExtend),
      .in_Ctrl              (in_Ctrl),
      .out_Instruction      (out_Instruction),
      .out_PC_4             (out_PC_4),
      .out_ReadData1        (out_ReadData1),
      .out_ReadData2        (out_ReadData2),
      .out_InmmediateExtend (out_InmmediateExtend),
      .out_ShamtExtend      (out_ShamtExtend),
      .out_Ctrl             (out_Ctrl),
      .out_WriteRegister    (out_WriteRegister),
      .out_Stall            (out_Stall),
      .out_StallCount       (out_StallCount),
      .out_FlushCount       (out_FlushCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic [31:0] instr;
      logic [15:0] ctrl;
      logic        exp_stall;   // out_Stall while these inputs are applied
      logic        exp_bubble;  // register loads a bubble on the edge
      logic [4:0]  exp_wr;
      logic [15:0] exp_sc;
      logic [15:0] exp_fc;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic f, input logic [31:0] ins, input logic [15:0] c,
                               input logic st, input logic bub, input logic [4:0] wr,
                               input logic [15:0] sc, input logic [15:0] fc);
      vec_t v;
      v.flush = f; v.instr = ins; v.ctrl = c; v.exp_stall = st; v.exp_bubble = bub;
      v.exp_wr = wr; v.exp_sc = sc; v.exp_fc = fc;
      return v;
   endfunction

   task automatic drive(input logic f, input logic [31:0] ins, input logic [15:0] c, input int k);
      in_Flush            = f;
      in_Instruction      = ins;
      in_Ctrl             = c;
      in_PC_4             = 32'h0040_0000 + 32'(k) * 4;
      in_ReadData1        = 32'h1000_0000 + 32'(k);
      in_ReadData2        = 32'hA5A5_0000 ^ 32'(k);
      in_InmmediateExtend = 32'(k) * 3;
      in_ShamtExtend      = 32'(k) & 32'h1F;
   endtask

   initial begin
      vecs[0]  = mk(0, I_ADD3,    C_RTYPE, 0, 0, 5'd3,  16'd0, 16'd0);
      vecs[1]  = mk(0, I_LW8,     C_LW,    0, 0, 5'd8,  16'd0, 16'd0);
      vecs[2]  = mk(0, I_ADD_RS8, C_RTYPE, 1, 1, 5'd0,  16'd1, 16'd0);
      vecs[3]  = mk(0, I_ADD_RS8, C_RTYPE, 0, 0, 5'd10, 16'd1, 16'd0);
      vecs[4]  = mk(0, I_LW0,     C_LW,    0, 0, 5'd0,  16'd1, 16'd0);
      vecs[5]  = mk(0, I_ADD_RS0, C_RTYPE, 0, 0, 5'd10, 16'd1, 16'd0);
      vecs[6]  = mk(0, I_LW8,     C_LW,    0, 0, 5'd8,  16'd1, 16'd0);
      vecs[7]  = mk(0, I_ADD_IND, C_RTYPE, 0, 0, 5'd14, 16'd1, 16'd0);
      vecs[8]  = mk(0, I_LW8,     C_LW,    0, 0, 5'd8,  16'd1, 16'd0);
      vecs[9]  = mk(0, I_ADD_RT8, C_RTYPE, 1, 1, 5'd0,  16'd2, 16'd0);
      vecs[10] = mk(0, I_ADD_RT8, C_RTYPE, 0, 0, 5'd10, 16'd2, 16'd0);
      vecs[11] = mk(0, I_LW8,     C_LW,    0, 0, 5'd8,  16'd2, 16'd0);
      vecs[12] = mk(1, I_ADD_RS8, C_RTYPE, 0, 1, 5'd0,  16'd2, 16'd1);
      vecs[13] = mk(0, I_ADD_RS8, C_RTYPE, 0, 0, 5'd10, 16'd2, 16'd1);
      vecs[14] = mk(1, I_ADD3,    C_RTYPE, 0, 1, 5'd0,  16'd2, 16'd2);

      // Reset held with random inputs and a running clock
      reset = 1'b0;
      in_Flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'($urandom), $urandom, 16'($urandom), k + 100);
      end
      @(posedge clk);
      #1;
      chk("rst_instr", out_Instruction, 32'h0);
      chk("rst_ctrl",  32'(out_Ctrl), 32'h0);
      chk("rst_wr",    32'(out_WriteRegister), 32'h0);
      chk("rst_rd1",   out_ReadData1, 32'h0);
      chk("rst_pc4",   out_PC_4, 32'h0);
      chk("rst_stall", 32'(out_Stall), 32'h0);
      chk("rst_sc",    32'(out_StallCount), 32'h0);
      chk("rst_fc",    32'(out_FlushCount), 32'h0);

      @(negedge clk);
      reset = 1'b1;

      // Table-driven sequence
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].flush, vecs[i].instr, vecs[i].ctrl, i);
         #1;
         chk($sformatf("v%0d_stall", i), 32'(out_Stall), 32'(vecs[i].exp_stall));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_instr", i), out_Instruction,
             vecs[i].exp_bubble ? 32'h0 : vecs[i].instr);
         chk($sformatf("v%0d_ctrl", i), 32'(out_Ctrl),
             vecs[i].exp_bubble ? 32'h0 : 32'(vecs[i].ctrl));
         chk($sformatf("v%0d_wr", i), 32'(out_WriteRegister), 32'(vecs[i].exp_wr));
         chk($sformatf("v%0d_pc4", i), out_PC_4,
             vecs[i].exp_bubble ? 32'h0 : 32'h0040_0000 + 32'(i) * 4);
         chk($sformatf("v%0d_rd1", i), out_ReadData1,
             vecs[i].exp_bubble ? 32'h0 : 32'h1000_0000 + 32'(i));
         chk($sformatf("v%0d_rd2", i), out_ReadData2,
             vecs[i].exp_bubble ? 32'h0 : 32'hA5A5_0000 ^ 32'(i));
         chk($sformatf("v%0d_imm", i), out_InmmediateExtend,
             vecs[i].exp_bubble ? 32'h0 : 32'(i) * 3);
         chk($sformatf("v%0d_shamt", i), out_ShamtExtend,
             vecs[i].exp_bubble ? 32'h0 : 32'(i) & 32'h1F);
         chk($sformatf("v%0d_sc", i), 32'(out_StallCount), 32'(vecs[i].exp_sc));
         chk($sformatf("v%0d_fc", i), 32'(out_FlushCount), 32'(vecs[i].exp_fc));
         @(negedge clk);
      end

      // Async reset asserted mid-stall, between clock edges
      drive(0, I_LW8, C_LW, 50);
      @(posedge clk);
      @(negedge clk);
      drive(0, I_ADD_RS8, C_RTYPE, 51);
      #1;
      chk("mid_stall_pre", 32'(out_Stall), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_instr", out_Instruction, 32'h0);
      chk("mid_ctrl",  32'(out_Ctrl), 32'h0);
      chk("mid_rd1",   out_ReadData1, 32'h0);
      chk("mid_stall", 32'(out_Stall), 32'h0);
      chk("mid_sc",    32'(out_StallCount), 32'h0);
      chk("mid_fc",    32'(out_FlushCount), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_instr", out_Instruction, I_ADD_RS8);
      chk("post_rst_wr",    32'(out_WriteRegister), 32'd10);
      chk("post_rst_sc",    32'(out_StallCount), 32'h0);

      // Flush counter saturation
      @(negedge clk);
      drive(1, I_ADD_RS8, C_RTYPE, 60);
      repeat (65535) @(posedge clk);
      #1;
      chk("sat_fc_ffff", 32'(out_FlushCount), 32'hFFFF);
      chk("sat_bubble",  out_Instruction, 32'h0);
      repeat (6) @(posedge clk);
      #1;
      chk("sat_fc_hold", 32'(out_FlushCount), 32'hFFFF);
      chk("sat_sc",      32'(out_StallCount), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
Pipeline register between the ID and EX stages of the 5-stage MIPS core. It captures decoded operands, immediates, PC+4, the instruction word and the control bundle from ID, and presents them to EX one cycle later. It contains the load-use hazard detector, which stalls PC and IF/ID and injects a bubble. It also squashes the ID-stage instruction on a taken branch or jump resolved downstream, and keeps saturating stall and flush event counters for debug.

Parameters:
NBits, 32, datapath width of operand, immediate, PC and instruction fields.
CNT_WIDTH, 16, width of each event counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_Flush  in  1  taken branch or jump resolved in MEM; squash the ID instruction.
in_Instruction  in  NBits  ID-stage instruction word.
in_PC_4  in  NBits  ID-stage PC+4.
in_ReadData1  in  NBits  register file port 1.
in_ReadData2  in  NBits  register file port 2.
in_InmmediateExtend  in  NBits  sign-extended immediate.
in_ShamtExtend  in  NBits  zero-extended shamt.
in_Ctrl  in  16  control bundle from the control unit (layout in package).
out_Instruction  out  NBits  EX-stage instruction.
out_PC_4  out  NBits  EX-stage PC+4.
out_ReadData1, out_ReadData2, out_InmmediateExtend, out_ShamtExtend  out  NBits each  registered copies.
out_Ctrl  out  16  registered control bundle.
out_WriteRegister  out  5  registered destination: rd if RegDst, else rt.
out_Stall  out  1  combinational; hold PC and IF/ID this cycle.
out_StallCount  out  CNT_WIDTH  count of stall cycles, saturating.
out_FlushCount  out  CNT_WIDTH  count of flushes, saturating.

Behaviour:
- Reset is asynchronous, active-low (reset=0):
  - All registered outputs go to 0, so out_Instruction=0x00000000 (sll $0,$0,0, a NOP) and out_Ctrl=0.
  - Both counters go to 0.
  - out_Stall evaluates to 0 because out_Ctrl.MemRead=0.
- Latency is one cycle: values at ID on edge N appear at the outputs after edge N.
- Hazard detection is combinational:
  - hazard = out_Ctrl.MemRead AND out_Instruction[20:16]!=0 AND (out_Instruction[20:16]==in_Instruction[25:21] OR out_Instruction[20:16]==in_Instruction[20:16]).
  - out_Stall = hazard AND NOT in_Flush.
- Per-edge update has three cases, in priority order:
  - in_Flush=1: load a bubble (every data field 0, out_Ctrl=0, out_WriteRegister=0); FlushCount+1.
  - else hazard=1: load a bubble; StallCount+1.
  - else: load all inputs; out_WriteRegister = in_Ctrl.RegDst ? in_Instruction[15:11] : in_Instruction[20:16].
- A stall always lasts exactly 1 cycle. The bubble clears MemRead, so the next cycle's compare fails.
- Back-to-back loads stall only when the dependency is to the immediately preceding load.
- Flush and hazard in the same cycle: the flush wins, out_Stall=0, only FlushCount increments.
- Counters hold at all-ones and never wrap.
- Register $0 as the load destination never stalls.
- If reset asserts mid-stall, the bubble is dropped and the register comes out of reset holding the NOP.
- No other state; all flops are on clk with an async clear.

Decomposition:
- Package id_ex_pkg holds the in_Ctrl/out_Ctrl bit positions:
  - 0 RegDst, 1 BranchEQ, 2 BranchNE, 5:3 ALUOp, 6 ALUSrc, 7 RegWrite, 8 MemWrite, 9 MemRead, 10 MemtoReg, 11 ShamtSelector, 12 RegisterOrPC, 13 ALUMemOrPC, 14 Jump, 15 reserved (0).
  - It also holds CTRL_WIDTH=16 and NOP_INSTR=32'h0.
- Sub-module hazard_detection_unit: purely combinational; computes hazard from out_Ctrl.MemRead, the EX rt field and the ID rs/rt fields.
- The counters are inline.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs 0, out_Stall=0. Release reset, apply add $3,$1,$2 (0x00221820) with RegDst=1 and RegWrite=1 → next cycle out_Instruction=0x00221820, out_WriteRegister=3.
- Load-use: lw $8,0($9) then add $10,$8,$11 → after the lw edge out_Stall=1 for exactly one cycle, out_Ctrl becomes 0 for one cycle, StallCount=1; the add appears at the outputs one cycle later.
- No false hazard: lw $0,0($9) then add $10,$0,$11 → out_Stall stays 0. lw $8 then add using $12,$13 → no stall.
- Flush priority: a load-use condition plus in_Flush=1 on the same cycle → out_Stall=0, bubble loaded, FlushCount=1, StallCount unchanged.
- Saturation: 2^16+5 forced flushes → out_FlushCount=16'hFFFF, no wrap.
- Async reset mid-stall: drop reset between edges while out_Stall=1 → outputs clear immediately without waiting for a clock edge, and counters read 0.
